// File: rtl/prodesc_arb_pkg.sv
// Shared types and sizes for the produto_escalar arbiter: the operation
// state machine encoding and the operand/result geometry of the shared unit.
package prodesc_arb_pkg;

  localparam int VEC_LEN = 8;
  localparam int ELEM_W  = 8;
  localparam int RES_W   = 64;
  localparam int OPND_W  = VEC_LEN * ELEM_W;
  localparam int TMO_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after the
// pointer wins, wrapping back to the lowest index when none is found.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_any
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;
  logic             w_hi_any;
  logic             w_lo_any;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_hi_idx = '0;
    w_lo_idx = '0;
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    // Scanning downwards leaves the lowest qualifying index as the last write.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_idx = IDX_W'(i);
        w_lo_any = 1'b1;
        if (i >= int'(i_ptr)) begin
          w_hi_idx = IDX_W'(i);
          w_hi_any = 1'b1;
        end
      end
    end
    o_any = w_lo_any;
    o_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    o_gnt = w_lo_any ? (N_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/produto_escalar_arbiter.sv
// Shares one produto_escalar dot-product unit between N_REQ requesters with
// round-robin arbitration. Define PRODESC_ARB_TIMEOUT_EN to abort WAIT after
// TIMEOUT_CYCLES with an error response.
module produto_escalar_arbiter
  import prodesc_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*OPND_W-1:0] i_req_a,
  input  logic [N_REQ*OPND_W-1:0] i_req_b,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_rsp_valid,
  input  logic [N_REQ-1:0]        i_rsp_ready,
  output logic [RES_W-1:0]        o_rsp_result,
  output logic                    o_rsp_err,
  output logic                    o_busy,
  output logic                    o_pe_start,
  output logic [OPND_W-1:0]       o_pe_a,
  output logic [OPND_W-1:0]       o_pe_b,
  input  logic                    i_pe_done,
  input  logic [RES_W-1:0]        i_pe_result
);

  localparam int IDX_W = $clog2(N_REQ);

  // An illegal configuration elaborates this empty scope, visible in the hierarchy.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_illegal_config
  end

  state_e             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_win;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic               r_pe_start;
  logic [OPND_W-1:0]  r_pe_a;
  logic [OPND_W-1:0]  r_pe_b;
  logic [RES_W-1:0]   r_rsp_result;

  logic [N_REQ-1:0]   w_win_oh;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_any;
  logic               w_win_ready;
  logic [IDX_W-1:0]   w_ptr_next;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_win_oh),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  assign w_win_ready = i_rsp_ready[r_win];
  assign w_ptr_next  = (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + IDX_W'(1);

`ifdef PRODESC_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic             r_rsp_err;
  logic [TMO_W-1:0] r_tmo_cnt;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_win        <= '0;
      r_gnt        <= '0;
      r_rsp_valid  <= '0;
      r_pe_start   <= 1'b0;
      r_pe_a       <= '0;
      r_pe_b       <= '0;
      r_rsp_result <= '0;
`ifdef PRODESC_ARB_TIMEOUT_EN
      r_rsp_err    <= 1'b0;
      r_tmo_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_win_any) begin
          r_pe_a     <= i_req_a[w_win_idx*OPND_W +: OPND_W];
          r_pe_b     <= i_req_b[w_win_idx*OPND_W +: OPND_W];
          r_win      <= w_win_idx;
          r_gnt      <= w_win_oh;
          r_pe_start <= 1'b1;
          r_state    <= START;
        end
        START: begin
          r_gnt      <= '0;
          r_pe_start <= 1'b0;
          r_state    <= WAIT;
`ifdef PRODESC_ARB_TIMEOUT_EN
          r_tmo_cnt  <= '0;
`endif
        end
        WAIT: if (i_pe_done) begin
          r_rsp_result <= i_pe_result;
          r_rsp_valid  <= N_REQ'(1) << r_win;
          r_state      <= RESP;
`ifdef PRODESC_ARB_TIMEOUT_EN
          r_rsp_err    <= 1'b0;
        end else if (r_tmo_cnt == TMO_LAST) begin
          // The unit is abandoned; a late done is dropped because we leave WAIT.
          r_rsp_result <= '0;
          r_rsp_err    <= 1'b1;
          r_rsp_valid  <= N_REQ'(1) << r_win;
          r_state      <= RESP;
        end else begin
          r_tmo_cnt    <= r_tmo_cnt + TMO_W'(1);
`endif
        end
        RESP: if (w_win_ready) begin
          r_rsp_valid <= '0;
          r_ptr       <= w_ptr_next;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt        = r_gnt;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_busy       = (r_state != IDLE);
  assign o_pe_start   = r_pe_start;
  assign o_pe_a       = r_pe_a;
  assign o_pe_b       = r_pe_b;
`ifdef PRODESC_ARB_TIMEOUT_EN
  assign o_rsp_err    = r_rsp_err;
`else
  assign o_rsp_err    = 1'b0;
`endif

endmodule

// File: doc/produto_escalar_arbiter.md
Name: produto_escalar_arbiter

Overview:
- Shares one produto_escalar unit (8x int8 dot product, 64-bit signed result, start/done) between N_REQ requesters.
- Sits between the SoC-side requesters (CPU CSR bridge, accelerator ports) and the single shared unit.
- Arbitrates round-robin and latches the winner's operands.
- Sequences start/done with the shared unit and returns the result to the winner over a per-requester valid/ready response.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, cycles in WAIT before abort; used only with PRODESC_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  N_REQ  per-requester request level.
- i_req_a  in  N_REQ*64  operand A per requester; 8 signed bytes, element 0 in bits [7:0].
- i_req_b  in  N_REQ*64  operand B per requester, same packing as i_req_a.
- o_gnt  out  N_REQ  one-hot, one-cycle pulse: operands captured.
- o_rsp_valid  out  N_REQ  one-hot; result valid for that requester.
- i_rsp_ready  in  N_REQ  per-requester response accept.
- o_rsp_result  out  64  signed result, shared bus.
- o_rsp_err  out  1  timeout flag, qualified by o_rsp_valid.
- o_busy  out  1  high whenever state != IDLE.
- o_pe_start  out  1  start pulse to the shared unit.
- o_pe_a  out  64  latched operand A to the shared unit.
- o_pe_b  out  64  latched operand B to the shared unit.
- i_pe_done  in  1  done from the shared unit (level or pulse).
- i_pe_result  in  64  result from the shared unit.

Behaviour:
- Reset (rst=0, async): state=IDLE; rr pointer=0; all outputs 0, including o_pe_a/o_pe_b and o_rsp_result.
- IDLE, no request: remains IDLE.
- IDLE, any i_req bit set at an edge, same edge:
  - winner w = first set bit at or after the rr pointer, wrapping modulo N_REQ;
  - i_req_a[w], i_req_b[w] latched into o_pe_a, o_pe_b;
  - w stored; go to START.
- START (exactly 1 cycle): o_gnt[w]=1, o_pe_start=1; go to WAIT.
- WAIT:
  - o_pe_start=0; o_pe_a/o_pe_b held stable.
  - i_pe_done=1 at an edge: i_pe_result captured into o_rsp_result, o_rsp_err=0; go to RESP.
  - The shared unit must drop any stale done within the START cycle; i_pe_done is ignored outside WAIT.
- RESP:
  - o_rsp_valid[w]=1; o_rsp_result and o_rsp_err held until i_rsp_ready[w]=1 at an edge.
  - On that edge: rr pointer=(w+1) mod N_REQ; go to IDLE.
  - i_rsp_ready of non-winners is ignored.
- Minimum throughput: IDLE, START, WAIT (>=1 cycle), RESP (>=1 cycle) = 4 cycles per operation.
- Requesters hold i_req and operands until o_gnt. Dropping i_req before grant withdraws the request silently. Operands may change freely after o_gnt.
- i_req[w] may stay high after grant. It is a new request, eligible only after RESP, at lowest rr priority.
- Simultaneous requests: the rr pointer decides. A requester is never starved; worst-case wait is N_REQ-1 full operations.
- Only the winner's response bit is ever asserted (one-hot or zero).
- Async reset mid-operation: aborts immediately, no response is issued, and the shared unit receives no further start. Requesters must re-request.
- Results pass through unmodified; arithmetic belongs to the shared unit.

Optional Feature:
- PRODESC_ARB_TIMEOUT_EN defined:
  - 16-bit counter cleared on WAIT entry, incremented each WAIT cycle.
  - At TIMEOUT_CYCLES with no done: go to RESP with o_rsp_result=0, o_rsp_err=1.
  - Late done is ignored; the next START restarts the shared unit.
- Not defined: no counter; WAIT lasts indefinitely; o_rsp_err tied 0.

Decomposition:
- Package prodesc_arb_pkg:
  - state enum {IDLE, START, WAIT, RESP};
  - localparams VEC_LEN=8, ELEM_W=8, RES_W=64, OPND_W=VEC_LEN*ELEM_W.
- Sub-module rr_arbiter (combinational, N_REQ-param): inputs request vector and pointer; outputs one-hot winner and index.

Test Plan:
- Single request, req0 with a[i]=i, b[i]=8-i: o_gnt[0] pulse; one o_pe_start; o_rsp_valid[0] with o_rsp_result=84, o_rsp_err=0.
- req0 and req1 asserted together at reset, req0 a=all 1, b=all 2 (16); req1 a=all -1, b=all 3 (-24): req0 served first (16), then req1 (-24). With both re-requesting, grants alternate 0,1,0,1.
- Shared-unit model with done delayed 10 cycles and i_rsp_ready held low 5 cycles: result stable across the stall; exactly one start per operation; o_busy high throughout.
- req1 dropped before its grant while req0 is served: no o_gnt[1]; arbiter returns to IDLE after req0.
- Assert rst low during WAIT: all outputs 0 immediately; fresh req0 afterwards completes normally with the correct result.
- With PRODESC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, done never asserted: o_rsp_valid after 8 WAIT cycles with result 0, o_rsp_err=1. Without the macro, the arbiter stays in WAIT.
